// File: rtl/wb_timeout_guard.sv
// Wishbone watchdog: passes master traffic to the decode mux and answers with an error ack
// if no ack arrives in time. Define WB_TIMEOUT_STATUS_EN to add abort count/address registers.
module wb_timeout_guard #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] io_wbs_adr,
  input  logic [31:0] io_wbs_datwr,
  output logic [31:0] io_wbs_datrd,
  input  logic        io_wbs_we,
  input  logic        io_wbs_stb,
  output logic        io_wbs_ack,
  input  logic        io_wbs_cyc,
  output logic [31:0] io_wbs_adr_d,
  output logic [31:0] io_wbs_datwr_d,
  input  logic [31:0] io_wbs_datrd_d,
  output logic        io_wbs_we_d,
  output logic        io_wbs_stb_d,
  input  logic        io_wbs_ack_d,
  output logic        io_wbs_cyc_d,
  output logic        timeout_o,
  output logic [15:0] err_count_o,
  output logic [31:0] err_addr_o
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_c, wait_c, abort_c;

  assign req_c   = io_wbs_cyc & io_wbs_stb;
  assign wait_c  = req_c & ~io_wbs_ack_d & (state_q != S_ERR);
  assign abort_c = wait_c & (cnt_q == CNT_LAST);

  assign io_wbs_adr_d   = io_wbs_adr;
  assign io_wbs_datwr_d = io_wbs_datwr;
  assign io_wbs_we_d    = io_wbs_we;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_WAIT: begin
        if (abort_c) begin
          state_d = S_ERR;
          cnt_d   = '0;
        end else if (wait_c) begin
          state_d = S_WAIT;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Upstream ack is qualified by the live request so a stray ack_d never reaches the master.
  always_comb begin
    io_wbs_ack   = 1'b0;
    io_wbs_datrd = '0;
    io_wbs_stb_d = 1'b0;
    io_wbs_cyc_d = 1'b0;
    timeout_o    = 1'b0;
    if (!wb_rst_i) begin
      case (state_q)
        S_ERR: begin
          io_wbs_ack   = 1'b1;
          io_wbs_datrd = ERR_DATA;
          timeout_o    = 1'b1;
        end
        default: begin
          io_wbs_ack   = io_wbs_ack_d & req_c;
          io_wbs_datrd = io_wbs_datrd_d;
          io_wbs_stb_d = io_wbs_stb;
          io_wbs_cyc_d = io_wbs_cyc;
        end
      endcase
    end
  end

`ifdef WB_TIMEOUT_STATUS_EN
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] err_addr_q, err_addr_d;

  always_comb begin
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    if (abort_c) begin
      err_addr_d = io_wbs_adr;
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_count_o = err_count_q;
  assign err_addr_o  = err_addr_q;
`else
  assign err_count_o = '0;
  assign err_addr_o  = '0;
`endif

endmodule

// File: tb/tb_wb_timeout_guard.sv
// Bench for wb_timeout_guard: directed vector table, hand sequences and random traffic
// against a run-length reference model. Honours WB_TIMEOUT_STATUS_EN.
module tb_wb_timeout_guard;
  localparam int T = 16;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] adr = '0, datwr = '0, datrd, adr_d, datwr_d, datrd_d = '0;
  logic        we = 1'b0, stb = 1'b0, ack, cyc = 1'b0, we_d, stb_d, ack_d = 1'b0, cyc_d, tmo;
  logic [15:0] err_count;
  logic [31:0] err_addr;

  always #5 clk = ~clk;

  wb_timeout_guard #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERRD)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
    .io_wbs_datrd(datrd), .io_wbs_we(we), .io_wbs_stb(stb), .io_wbs_ack(ack),
    .io_wbs_cyc(cyc), .io_wbs_adr_d(adr_d), .io_wbs_datwr_d(datwr_d),
    .io_wbs_datrd_d(datrd_d), .io_wbs_we_d(we_d), .io_wbs_stb_d(stb_d),
    .io_wbs_ack_d(ack_d), .io_wbs_cyc_d(cyc_d), .timeout_o(tmo),
    .err_count_o(err_count), .err_addr_o(err_addr)
  );

  int vectors = 0, miscompares = 0;

  // Reference model: length of the current run of consecutive unacked wait cycles.
  int          m_run = 0;
  bit          m_err = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [31:0] m_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_err = 1'b0; m_cnt = '0; m_addr = '0;
  endtask

  task automatic step(input logic c, input logic s, input logic a, input logic [31:0] ad,
                      input logic [31:0] rd);
    logic req;
    @(negedge clk);
    cyc = c; stb = s; ack_d = a; adr = ad; datrd_d = rd;
    we = 1'($urandom_range(0, 1)); datwr = $urandom;
    #1;
    req = c & s;
    chk("ack",   32'(ack),   m_err ? 32'd1 : 32'(a & req));
    chk("datrd", datrd,      m_err ? ERRD : rd);
    chk("stb_d", 32'(stb_d), m_err ? 32'd0 : 32'(s));
    chk("cyc_d", 32'(cyc_d), m_err ? 32'd0 : 32'(c));
    chk("timeout", 32'(tmo), 32'(m_err));
    chk("adr_d", adr_d, ad);
    chk("datwr_d", datwr_d, datwr);
    chk("we_d", 32'(we_d), 32'(we));
`ifdef WB_TIMEOUT_STATUS_EN
    chk("err_count", 32'(err_count), 32'(m_cnt));
    chk("err_addr", err_addr, m_addr);
`else
    chk("err_count", 32'(err_count), 32'd0);
    chk("err_addr", err_addr, 32'd0);
`endif
    // Advance the model across the coming clock edge.
    if (m_err) begin
      m_err = 1'b0; m_run = 0;
    end else if (req && !a) begin
      m_run++;
      if (m_run == T) begin
        m_err = 1'b1; m_run = 0; m_addr = ad;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; ack_d = 1'b0; rst = 1'b1;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    chk("rst_addr", err_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic c, s, a;
    logic [31:0] rd;
    logic e_ack;
    logic [31:0] e_rd;
    logic e_stb, e_cyc, e_to;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic c, s, a, input logic [31:0] rd, input logic e_ack,
                              input logic [31:0] e_rd, input logic e_stb, e_cyc, e_to);
    vec_t v;
    v.c = c; v.s = s; v.a = a; v.rd = rd; v.e_ack = e_ack; v.e_rd = e_rd;
    v.e_stb = e_stb; v.e_cyc = e_cyc; v.e_to = e_to;
    return v;
  endfunction

  initial begin
    // 3 wait cycles then ack with data
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h1234, 1, 32'h1234, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // hung access: 16 pass-through cycles, error ack with ack_d pulsed, late ack dropped
    for (int i = 0; i < T; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h7777, 1, ERRD, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    // next read acked after 2 waits
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 32'h5555, 1, 32'h5555, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    #2;
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_stb_d", 32'(stb_d), 32'd0);
    chk("reset_cyc_d", 32'(cyc_d), 32'd0);
    chk("reset_tmo", 32'(tmo), 32'd0);
    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].s, tbl[i].a, 32'h30000004, tbl[i].rd);
      chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_datrd", i), datrd, tbl[i].e_rd);
      chk($sformatf("tbl%0d_stb_d", i), 32'(stb_d), 32'(tbl[i].e_stb));
      chk($sformatf("tbl%0d_cyc_d", i), 32'(cyc_d), 32'(tbl[i].e_cyc));
      chk($sformatf("tbl%0d_tmo", i), 32'(tmo), 32'(tbl[i].e_to));
    end

    // Abandon after 10 waits, reissue: 16 fresh waits needed, then zero-wait ack.
    for (int i = 0; i < 10; i++) step(1, 1, 0, 32'h30000008, 0);
    step(1, 0, 0, 32'h30000008, 0);
    for (int i = 0; i < T; i++) begin
      step(1, 1, 0, 32'h30000008, 0);
      chk("reissue_no_tmo", 32'(tmo), 32'd0);
    end
    step(0, 0, 0, 0, 0);
    chk("reissue_tmo", 32'(tmo), 32'd1);
    step(1, 1, 1, 32'h30000010, 32'hABCD);
    chk("zero_wait_ack", 32'(ack), 32'd1);
    chk("zero_wait_data", datrd, 32'hABCD);

    // Asynchronous reset in the middle of wait cycle 8.
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h30000020, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_stb_d", 32'(stb_d), 32'd0);
    chk("arst_cyc_d", 32'(cyc_d), 32'd0);
    chk("arst_tmo", 32'(tmo), 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    model_reset();
    for (int i = 0; i < T; i++) begin
      step(1, 1, 0, 32'h30000020, 0);
      chk("post_rst_no_tmo", 32'(tmo), 32'd0);
    end
    step(0, 0, 0, 0, 0);
    chk("post_rst_tmo", 32'(tmo), 32'd1);

    // Two aborts at distinct addresses, then saturation.
    do_reset();
    for (int i = 0; i < T; i++) step(1, 1, 0, 32'h30000100, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < T; i++) step(1, 1, 0, 32'h30001200, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
`ifdef WB_TIMEOUT_STATUS_EN
    chk("status_count2", 32'(err_count), 32'd2);
    chk("status_addr", err_addr, 32'h30001200);
    @(negedge clk);
    force dut.err_count_q = 16'hFFFF;
    #1 release dut.err_count_q;
    m_cnt = 16'hFFFF;
    for (int i = 0; i < T; i++) step(1, 1, 0, 32'h30002000, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("status_sat", 32'(err_count), 32'hFFFF);
    chk("status_sat_addr", err_addr, 32'h30002000);
`endif

    // Random traffic biased towards long unacked waits.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 15) != 0),
           1'($urandom_range(0, 19) == 0), $urandom, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
